// File: rtl/uart_frame_tx.sv
// Multi-byte 8N1 serial transmitter: sends NUM_BYTES bytes back to back,
// byte 0 first, LSB first, with a start/busy/done handshake.
module uart_frame_tx #(
  parameter int BIT_PER   = 2604,
  parameter int NUM_BYTES = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*NUM_BYTES-1:0] tx_data,
  input  logic                   tx_start,
  output logic                   txd,
  output logic                   busy,
  output logic                   done
);

  localparam int BW = (BIT_PER > 1) ? $clog2(BIT_PER) : 1;
  localparam int YW = $clog2(NUM_BYTES) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_PER - 1);
  localparam logic [YW-1:0] BYTE_LAST = YW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state, state_n;
  logic [BW-1:0]          baud_cnt, baud_n;
  logic [3:0]             bit_cnt, bit_n;
  logic [YW-1:0]          byte_cnt, byte_n;
  logic [8*NUM_BYTES-1:0] shift_reg, shift_n;
  logic                   txd_n, busy_n, done_n;
  logic                   bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  // State, counters and the registered outputs; reset abandons any frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      shift_reg <= '0;
      txd       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      byte_cnt  <= byte_n;
      shift_reg <= shift_n;
      txd       <= txd_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // Next state; txd is computed one step ahead so the line stays registered.
  // The whole frame sits in one shift register, so after byte k's 8 shifts
  // bit 0 already holds byte k+1's LSB.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    byte_n  = byte_cnt;
    shift_n = shift_reg;
    txd_n   = txd;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        txd_n  = 1'b1;
        busy_n = 1'b0;
        if (tx_start) begin
          shift_n = tx_data;
          baud_n  = '0;
          bit_n   = '0;
          byte_n  = '0;
          state_n = START;
          txd_n   = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          baud_n  = '0;
          state_n = DATA;
          txd_n   = shift_reg[0];
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n  = '0;
          shift_n = shift_reg >> 1;
          bit_n   = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            state_n = STOP;
            txd_n   = 1'b1;
          end else begin
            txd_n = shift_reg[1];
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_n = '0;
          if (byte_cnt != BYTE_LAST) begin
            byte_n  = byte_cnt + 1'b1;
            bit_n   = '0;
            state_n = START;
            txd_n   = 1'b0;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            txd_n   = 1'b1;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: a 1-byte and a 2-byte instance at 4 clocks/bit,
// checked cycle by cycle against line patterns from a table and from a
// frame model built directly from the 8N1 framing rules.
module tb_uart_frame_tx;
  localparam int BP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic [7:0]  data_a;
  logic [15:0] data_b;
  logic        txd_a, busy_a, done_a;
  logic        txd_b, busy_b, done_b;
  bit          sel;
  logic        txd_s, busy_s, done_s;
  int          n_chk = 0;
  int          n_pass = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // bit i = i-th bit on the wire
  } vec_t;
  vec_t tbl[6];

  uart_frame_tx #(.BIT_PER(BP), .NUM_BYTES(1)) u_one (
    .clk(clk), .reset(reset), .tx_data(data_a), .tx_start(start_a),
    .txd(txd_a), .busy(busy_a), .done(done_a));

  uart_frame_tx #(.BIT_PER(BP), .NUM_BYTES(2)) u_two (
    .clk(clk), .reset(reset), .tx_data(data_b), .tx_start(start_b),
    .txd(txd_b), .busy(busy_b), .done(done_b));

  always #5 clk = ~clk;

  assign txd_s  = sel ? txd_b  : txd_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign done_s = sel ? done_b : done_a;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic drive_start(input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic drive_data(input logic [15:0] d);
    if (sel) data_b = d; else data_a = d[7:0];
  endtask

  // Wire image of a frame: per byte a 0 start bit, 8 data bits LSB first, a 1 stop bit.
  function automatic logic [79:0] line_bits(input logic [15:0] d, input int nb);
    logic [79:0] r = '0;
    for (int k = 0; k < nb; k++) begin
      r[10*k] = 1'b0;
      for (int b = 0; b < 8; b++) r[10*k+1+b] = d[8*k+b];
      r[10*k+9] = 1'b1;
    end
    return r;
  endfunction

  // Called at a negedge with the DUT idle (or on its done cycle when chaining).
  // noise: a mid-frame start pulse, one two cycles before done, and a data change.
  // keep: tx_start stays high throughout and the task returns on the done cycle.
  task automatic frame(input bit s, input int nb, input logic [15:0] d,
                       input logic [79:0] exp, input bit noise, input bit keep);
    int len, kp, kd;
    sel = s;
    len = 10 * BP * nb;
    kp  = $urandom_range(1, len - 4);
    kd  = $urandom_range(1, len - 3);
    drive_data(d);
    drive_start(1'b1);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < len; k++) begin
      chk("txd", 32'(txd_s), 32'(exp[k/BP]));
      chk("busy", 32'(busy_s), 32'd1);
      chk("done_early", 32'(done_s), 32'd0);
      drive_start(keep | (noise && (k == kp || k == len - 2)));
      if (noise && k == kd) drive_data(16'($urandom));
      @(negedge clk);
    end
    chk("done_pulse", 32'(done_s), 32'd1);
    chk("busy_end", 32'(busy_s), 32'd0);
    chk("txd_end", 32'(txd_s), 32'd1);
    if (!keep) begin
      @(negedge clk);
      chk("done_clear", 32'(done_s), 32'd0);
      chk("busy_idle", 32'(busy_s), 32'd0);
      chk("txd_idle", 32'(txd_s), 32'd1);
    end
  endtask

  initial begin
    logic [15:0] d, d2;
    tbl[0] = '{8'hA5, 10'h34A};
    tbl[1] = '{8'h00, 10'h200};
    tbl[2] = '{8'hFF, 10'h3FE};
    tbl[3] = '{8'h01, 10'h202};
    tbl[4] = '{8'h80, 10'h300};
    tbl[5] = '{8'h3C, 10'h278};

    // Reset held with tx_start high: outputs stay idle.
    reset = 1'b0; start_a = 1'b1; start_b = 1'b1; data_a = 8'h5A; data_b = 16'h1234;
    repeat (5) begin
      @(negedge clk);
      chk("rst_txd_a", 32'(txd_a), 32'd1);
      chk("rst_busy_a", 32'(busy_a), 32'd0);
      chk("rst_done_a", 32'(done_a), 32'd0);
      chk("rst_txd_b", 32'(txd_b), 32'd1);
      chk("rst_busy_b", 32'(busy_b), 32'd0);
      chk("rst_done_b", 32'(done_b), 32'd0);
    end
    // Release with tx_start still high: the frame starts on the next edge.
    reset = 1'b1; start_a = 1'b0;
    frame(1'b1, 2, 16'h1234, line_bits(16'h1234, 2), 1'b0, 1'b0);

    // Table of single-byte frames.
    for (int i = 0; i < 6; i++)
      frame(1'b0, 1, {8'h00, tbl[i].data}, {70'b0, tbl[i].line}, 1'b0, 1'b0);
    frame(1'b0, 1, {8'h00, tbl[0].data}, {70'b0, tbl[0].line}, 1'b1, 1'b0);

    // Random two-byte frames against the model, with random busy noise.
    repeat (20) begin
      d = 16'($urandom);
      frame(1'b1, 2, d, line_bits(d, 2), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Back-to-back with tx_start held, data disturbed during the first frame.
    d  = 16'($urandom);
    d2 = 16'($urandom);
    frame(1'b1, 2, d, line_bits(d, 2), 1'b1, 1'b1);
    frame(1'b1, 2, d2, line_bits(d2, 2), 1'b0, 0);

    // Asynchronous reset during byte 1's data bits.
    sel = 1'b1;
    data_b = 16'hC3E7; start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    repeat (50) @(negedge clk);
    chk("mid_busy_before", 32'(busy_b), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_txd", 32'(txd_b), 32'd1);
    chk("async_busy", 32'(busy_b), 32'd0);
    chk("async_done", 32'(done_b), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_done", 32'(done_b), 32'd0);
      chk("rst_hold_busy", 32'(busy_b), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 32'(done_b), 32'd0);
    chk("post_rst_txd", 32'(txd_b), 32'd1);
    frame(1'b1, 2, 16'hBEEF, line_bits(16'hBEEF, 2), 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
